// File: rtl/vec_pe_pkg.sv
// vec_pe_pkg: width helpers shared by the dot-product datapath and its scheduler.
package vec_pe_pkg;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int dot_width(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant of one requester per enabled cycle, scanning upward from rr_ptr.
module rr_arbiter
    import vec_pe_pkg::*;
#(
    parameter int R = 4,
    localparam int W_ID = clog2_min1(R)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [R-1:0]    req,
    input  logic            en,
    output logic [R-1:0]    gnt,
    output logic [W_ID-1:0] gnt_idx
);

    logic [W_ID-1:0] ptr_q, ptr_d, c;
    logic found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        c       = '0;
        for (int o = 0; o < R; o++) begin
            c = W_ID'((int'(ptr_q) + o) % R);
            if (!found && req[c]) begin
                found   = 1'b1;
                gnt_idx = c;
            end
        end
        gnt   = (en && found) ? R'(1) << gnt_idx : '0;
        ptr_d = (en && found) ? W_ID'((int'(gnt_idx) + 1) % R) : ptr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vec_mul.sv
// vec_mul: pipelined signed dot product; one product stage followed by a registered adder tree.
module vec_mul
    import vec_pe_pkg::*;
#(
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int DEPTH = $clog2(C),
    localparam int N     = 1 << DEPTH,
    localparam int W_Y   = dot_width(W_X, W_K, C)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic signed [W_K-1:0] k [C],
    input  logic signed [W_X-1:0] x [C],
    output logic signed [W_Y-1:0] y,
    output logic                  v_valid
);

    logic signed [W_Y-1:0] prod [N];
    logic [DEPTH:0] vld_q;

    // Tree is padded to a power of two with zero leaves.
    always_comb begin
        for (int j = 0; j < N; j++) prod[j] = '0;
        for (int j = 0; j < C; j++) prod[j] = W_Y'(k[j]) * W_Y'(x[j]);
    end

    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        logic signed [W_Y-1:0] s_q [N >> l];
        if (l == 0) begin : g_leaf
            always_ff @(posedge clk) begin
                if (enable) s_q <= prod;
            end
        end else begin : g_node
            always_ff @(posedge clk) begin
                if (enable)
                    for (int j = 0; j < (N >> l); j++)
                        s_q[j] <= g_lvl[l-1].s_q[2*j] + g_lvl[l-1].s_q[2*j+1];
            end
        end
    end

    assign y = g_lvl[DEPTH].s_q[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
        end else if (enable) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i <= DEPTH; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign v_valid = vld_q[DEPTH];

endmodule

// File: rtl/vec_mul_sched.sv
// vec_mul_sched: shares one pipelined vec_mul between R requesters with round-robin issue,
// a {valid,id} tag pipeline alongside the data and a stalling valid/ready result port.
module vec_mul_sched
    import vec_pe_pkg::*;
#(
    parameter int R   = 4,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int DEPTH = $clog2(C),
    localparam int LAT   = DEPTH + 1,
    localparam int W_Y   = dot_width(W_X, W_K, C),
    localparam int W_ID  = clog2_min1(R),
    localparam int W_CNT = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [R-1:0]          req_valid,
    output logic [R-1:0]          req_ready,
    input  logic signed [W_K-1:0] req_k [R][C],
    input  logic signed [W_X-1:0] req_x [R][C],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [W_Y-1:0] out_y,
    output logic [W_ID-1:0]       out_id,
    output logic [W_CNT-1:0]      inflight,
    output logic                  idle
);

    logic advance, xfer;
    logic [W_ID-1:0] gnt_idx;
    logic signed [W_K-1:0] k_mux [C];
    logic signed [W_X-1:0] x_mux [C];
    logic signed [W_Y-1:0] y;
    logic [LAT-1:0] tv_q;
    logic [W_ID-1:0] tid_q [LAT];
    logic [W_CNT-1:0] inflight_q, inflight_d;

    assign advance = !(out_valid && !out_ready);
    assign xfer    = |req_ready;

    rr_arbiter #(.R(R)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .en      (advance),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        for (int j = 0; j < C; j++) begin
            k_mux[j] = req_k[gnt_idx][j];
            x_mux[j] = req_x[gnt_idx][j];
        end
    end

    // Validity comes only from the tags, so the datapath's own valid is unused.
    vec_mul #(.C(C), .W_X(W_X), .W_K(W_K)) u_mul (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (advance),
        .in_valid (xfer),
        .k        (k_mux),
        .x        (x_mux),
        .y        (y),
        .v_valid  ()
    );

    assign inflight_d = inflight_q + W_CNT'(xfer) - W_CNT'(out_valid && out_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tv_q       <= '0;
            inflight_q <= '0;
            for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (advance) begin
                tv_q[0]  <= xfer;
                tid_q[0] <= gnt_idx;
                for (int i = 1; i < LAT; i++) begin
                    tv_q[i]  <= tv_q[i-1];
                    tid_q[i] <= tid_q[i-1];
                end
            end
        end
    end

    assign out_valid = tv_q[LAT-1];
    assign out_id    = tid_q[LAT-1];
    assign out_y     = out_valid ? y : '0;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == '0) && !(|req_valid);

endmodule

// File: tb/tb_vec_mul_sched.sv
// tb_vec_mul_sched: randomized scoreboard bench; expected results come from a plain dot-product
// and round-robin model, checked by a negedge monitor independent of the stimulus thread.
module tb_vec_mul_sched;

    localparam int R = 4;
    localparam int C = 8;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [R-1:0] req_valid = '0;
    logic [R-1:0] req_ready;
    logic signed [7:0] req_k [R][C];
    logic signed [7:0] req_x [R][C];
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [18:0] out_y;
    logic [1:0] out_id;
    logic [2:0] inflight;
    logic idle;

    int checks = 0;
    int failures = 0;

    typedef struct {int y; int id; int a;} exp_t;
    exp_t q[$];
    int ptr_m = 0;
    int adv_cnt = 0;
    bit head_seen = 1'b0;

    always #5 clk = ~clk;

    vec_mul_sched #(.R(R), .C(C), .W_X(8), .W_K(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_k     (req_k),
        .req_x     (req_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .inflight  (inflight),
        .idle      (idle)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input int i);
        int s = 0;
        for (int j = 0; j < C; j++) s += int'(req_k[i][j]) * int'(req_x[i][j]);
        return s;
    endfunction

    function automatic int exp_grant();
        if (out_valid && !out_ready) return -1;
        for (int o = 0; o < R; o++)
            if (req_valid[(ptr_m + o) % R]) return (ptr_m + o) % R;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            ptr_m = 0;
            head_seen = 1'b0;
        end else begin
            int g;
            bit had;
            chk("inflight", int'(inflight), q.size());
            chk("inflight_bound", int'(inflight <= 3'(LAT)), 1);
            chk("idle", int'(idle), int'(q.size() == 0 && req_valid == '0));
            had = 1'b0;
            if (!out_valid) begin
                chk("y_masked", int'(out_y), 0);
            end else if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                had = 1'b1;
                chk("out_y", int'(out_y), q[0].y);
                chk("out_id", int'(out_id), q[0].id);
                if (!head_seen) chk("latency", adv_cnt - q[0].a, LAT);
                head_seen = 1'b1;
            end
            g = exp_grant();
            chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                q.push_back('{dot(g), g, adv_cnt});
                ptr_m = (g + 1) % R;
            end
            if (had && out_ready) begin
                void'(q.pop_front());
                head_seen = 1'b0;
            end
            if (!(out_valid && !out_ready)) adv_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                req_k[i][j] = 8'($urandom);
                req_x[i][j] = 8'($urandom);
            end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(idle), 1);
    endtask

    task automatic single_job(input int id, input int kv, input int xv, input int exp);
        req_valid = '0;
        out_ready = 1'b1;
        wait_idle(30);
        for (int j = 0; j < C; j++) begin
            req_k[id][j] = 8'(kv);
            req_x[id][j] = 8'(xv);
        end
        req_valid = R'(1) << id;
        #1;
        chk("job_ready", int'(req_ready), 1 << id);
        step();
        req_valid = '0;
        repeat (LAT - 1) step();
        chk("job_valid", int'(out_valid), 1);
        chk("job_y", int'(out_y), exp);
        chk("job_id", int'(out_id), id);
        step();
        wait_idle(30);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_rand();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_id", int'(out_id), 0);
        chk("rst_inflight", int'(inflight), 0);
        rstn = 1'b1;
        #1;
        chk("rst_idle", int'(idle), 1);

        single_job(2, 3, -2, -48);

        req_valid = '1;
        for (int n = 0; n < 20; n++) begin
            fill_rand();
            step();
            if (n >= LAT) chk("full_inflight", int'(inflight), LAT);
        end

        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            fill_rand();
            step();
            chk("bp_ready", int'(req_ready), 0);
        end
        out_ready = 1'b1;
        repeat (10) begin
            fill_rand();
            step();
        end

        single_job(1, -128, -128, 131072);

        req_valid = '1;
        repeat (3) begin
            fill_rand();
            step();
        end
        chk("mid_inflight", int'(inflight), 3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_y", int'(out_y), 0);
        chk("mid_rst_inflight", int'(inflight), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("post_rst_grant", int'(req_ready), 1);
        repeat (6) begin
            fill_rand();
            step();
        end
        req_valid = '0;
        wait_idle(30);

        for (int n = 0; n < 12; n++) begin
            fill_rand();
            req_valid = R'(1) << $urandom_range(0, R - 1);
            step();
            req_valid = '0;
            repeat (2) step();
        end

        for (int n = 0; n < 300; n++) begin
            fill_rand();
            req_valid = R'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid = '0;
        out_ready = 1'b1;
        wait_idle(50);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
